rails_sequencer: RTL and testbench

- Power-rail sequencer for the SMU analog supplies; replaces direct SPI bit-banging of the rails register.
- Sequences the enables up and down in fixed order with a programmable inter-stage delay. Order up: OE, LP15V, LP30V, LP60V. Down: reverse.
- Handles an immediate hard-kill fault.
- Sits between the SPI register bank (supplies en, max_rail, kill, fault_clr) and the RAILS_* pins.

---
 rtl/rails_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_rails_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rails_sequencer.sv
// -----------------------------------------------------------------------------
// rails_sequencer
//
// Sequences the SMU analog supply enables up and down in a fixed order with a
// programmable per-stage delay, and hard-kills every rail on a fault request.
//
// Power-up order : OE (rails_oe_n low), LP15V, LP30V, LP60V
// Power-down     : reverse order, one item per stage
// Kill           : all rails off and OE released on the same edge, fault latched
//
// Parameters
//   DELAY  cycles per stage (1..65535), 12000 = 1 ms at 12 MHz
//   CNT_W  stage counter width, 2**CNT_W must exceed DELAY
//
// Ports
//   clk         in   system clock (XTALCLK domain)
//   rst         in   asynchronous active-high reset
//   en          in   level request, 1 = rails on, 0 = rails off
//   max_rail    in   highest rail to enable (0 = OE only .. 3 = all rails)
//   kill        in   immediate shutdown request, highest priority
//   fault_clr   in   single-cycle pulse, clears the latched fault
//   rails_oe_n  out  rail driver output enable, active low
//   rail_lp15v  out  LP15V enable
//   rail_lp30v  out  LP30V enable
//   rail_lp60v  out  LP60V enable
//   ready       out  requested rails all up
//   busy        out  sequencing in progress (up or down)
//   fault       out  fault latched
//   state       out  current state code (OFF=0 .. FAULT=7)
// -----------------------------------------------------------------------------
module rails_sequencer #(
    parameter int DELAY = 12000,
    parameter int CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] max_rail,
    input  logic       kill,
    input  logic       fault_clr,
    output logic       rails_oe_n,
    output logic       rail_lp15v,
    output logic       rail_lp30v,
    output logic       rail_lp60v,
    output logic       ready,
    output logic       busy,
    output logic       fault,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_OE    = 3'd1,
        ST_U15   = 3'd2,
        ST_U30   = 3'd3,
        ST_U60   = 3'd4,
        ST_ON    = 3'd5,
        ST_DOWN  = 3'd6,
        ST_FAULT = 3'd7
    } state_t;

    // The counter is loaded with DELAY-1 on stage entry and the stage ends on
    // the edge where it reads zero, giving exactly DELAY cycles per stage.
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DELAY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       max_q;       // max_rail latched at power-up
    logic             oe_n_q;
    // Rails kept as a thermometer code {lp60, lp30, lp15}: powering up shifts a
    // one in from the bottom, powering down shifts right. This makes the
    // "lp60 implies lp30 implies lp15" ordering hold by construction.
    logic [2:0]       rails_q;
    logic             ready_q;
    logic             busy_q;
    logic             fault_q;

    logic             cnt_zero;
    logic             next_rail_ok;
    state_t           next_up_state;

    assign cnt_zero = (cnt_q == '0);

    // Whether the rail following the current up-stage is requested, and the
    // state that turning it on leads to.
    always_comb begin
        next_rail_ok  = 1'b0;
        next_up_state = ST_ON;
        case (state_q)
            ST_OE: begin
                next_rail_ok  = (max_q != 2'd0);
                next_up_state = ST_U15;
            end
            ST_U15: begin
                next_rail_ok  = max_q[1];
                next_up_state = ST_U30;
            end
            ST_U30: begin
                next_rail_ok  = (max_q == 2'd3);
                next_up_state = ST_U60;
            end
            default: begin
                next_rail_ok  = 1'b0;
                next_up_state = ST_ON;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            max_q   <= 2'd0;
            oe_n_q  <= 1'b1;
            rails_q <= 3'b000;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
        end else if (kill) begin
            // Hard kill wins over every other request and over timer expiry.
            state_q <= ST_FAULT;
            cnt_q   <= '0;
            oe_n_q  <= 1'b1;
            rails_q <= 3'b000;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b1;
        end else begin
            case (state_q)
                ST_OFF: begin
                    if (en && !fault_q) begin
                        max_q   <= max_rail;
                        oe_n_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        cnt_q   <= CNT_RELOAD;
                        state_q <= ST_OE;
                    end
                end

                ST_OE, ST_U15, ST_U30, ST_U60, ST_ON: begin
                    if (!en) begin
                        // Start powering down: drop the highest item that is
                        // on. Any pending up-stage time is discarded.
                        ready_q <= 1'b0;
                        if (rails_q == 3'b000) begin
                            oe_n_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_OFF;
                        end else begin
                            rails_q <= rails_q >> 1;
                            busy_q  <= 1'b1;
                            cnt_q   <= CNT_RELOAD;
                            state_q <= ST_DOWN;
                        end
                    end else if (state_q != ST_ON) begin
                        if (cnt_zero) begin
                            if (next_rail_ok) begin
                                rails_q <= {rails_q[1:0], 1'b1};
                                cnt_q   <= CNT_RELOAD;
                                state_q <= next_up_state;
                            end else begin
                                // Remaining stages are above the latched
                                // maximum and are skipped outright.
                                ready_q <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= ST_ON;
                            end
                        end else begin
                            cnt_q <= cnt_q - CNT_ONE;
                        end
                    end
                end

                ST_DOWN: begin
                    // en is ignored here; power-up only restarts from OFF.
                    if (cnt_zero) begin
                        if (rails_q == 3'b000) begin
                            oe_n_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_OFF;
                        end else begin
                            rails_q <= rails_q >> 1;
                            cnt_q   <= CNT_RELOAD;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end

                ST_FAULT: begin
                    // Clearing needs the request dropped as well, so rails do
                    // not spring back up the cycle after the fault clears.
                    if (fault_clr && !en) begin
                        fault_q <= 1'b0;
                        state_q <= ST_OFF;
                    end
                end

                default: begin
                    state_q <= ST_OFF;
                end
            endcase
        end
    end

    assign rails_oe_n = oe_n_q;
    assign rail_lp15v = rails_q[0];
    assign rail_lp30v = rails_q[1];
    assign rail_lp60v = rails_q[2];
    assign ready      = ready_q;
    assign busy       = busy_q;
    assign fault      = fault_q;
    assign state      = state_q;

endmodule

// File: tb/tb_rails_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rails_sequencer
//
// Directed bench for rails_sequencer with DELAY=4. A level-count model of the
// rails (0 = all off, 1 = OE, 2..4 = OE plus 1..3 rails) with a cycles-left
// timer predicts every output; a compare process checks the DUT against it on
// every falling edge, together with the rail ordering invariants. Directed
// checks at hand-computed edges pin the model to the expected timeline.
// -----------------------------------------------------------------------------
module tb_rails_sequencer;

    localparam int DELAY = 4;

    localparam int M_OFF  = 0;
    localparam int M_UP   = 1;
    localparam int M_ON   = 2;
    localparam int M_DOWN = 3;
    localparam int M_FLT  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [1:0] max_rail = 2'd0;
    logic       kill = 1'b0;
    logic       fault_clr = 1'b0;
    logic       rails_oe_n;
    logic       rail_lp15v;
    logic       rail_lp30v;
    logic       rail_lp60v;
    logic       ready;
    logic       busy;
    logic       fault;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;
    int ec;

    rails_sequencer #(.DELAY(DELAY), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .max_rail   (max_rail),
        .kill       (kill),
        .fault_clr  (fault_clr),
        .rails_oe_n (rails_oe_n),
        .rail_lp15v (rail_lp15v),
        .rail_lp30v (rail_lp30v),
        .rail_lp60v (rail_lp60v),
        .ready      (ready),
        .busy       (busy),
        .fault      (fault),
        .state      (state)
    );

    always #5 clk = ~clk;

    // Edge counter: the first rising edge after reset release is edge 1.
    always @(posedge clk or posedge rst) begin
        if (rst) ec <= 0;
        else     ec <= ec + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (edge %0d, t=%0t)", name, act, exp, ec, $time);
        end
    endtask

    task automatic dchk(input string name, input int act, input int exp);
        chk(name, act, exp);
        if (act == exp) $display("ok   edge %0d %s = %0d", ec, name, act);
    endtask

    // ---------------- behavioural model ----------------
    int   m_lvl, m_mode, m_tmr, m_max;
    logic m_flt;

    always @(posedge clk or posedge rst) begin : model
        int   lvl, mode, tmr, mx;
        logic flt;
        if (rst) begin
            m_lvl  <= 0;
            m_mode <= M_OFF;
            m_tmr  <= 0;
            m_max  <= 0;
            m_flt  <= 1'b0;
        end else begin
            lvl = m_lvl; mode = m_mode; tmr = m_tmr; mx = m_max; flt = m_flt;
            if (kill) begin
                lvl = 0; mode = M_FLT; flt = 1'b1;
            end else begin
                case (mode)
                    M_OFF: if (en && !flt) begin
                        mx = int'(max_rail); lvl = 1; mode = M_UP; tmr = DELAY;
                    end
                    M_UP, M_ON: begin
                        if (!en) begin
                            lvl = lvl - 1;
                            if (lvl == 0) mode = M_OFF;
                            else begin mode = M_DOWN; tmr = DELAY; end
                        end else if (mode == M_UP) begin
                            tmr = tmr - 1;
                            if (tmr == 0) begin
                                // rail number lvl is the next one; wanted if <= max
                                if (lvl <= mx) begin lvl = lvl + 1; tmr = DELAY; end
                                else mode = M_ON;
                            end
                        end
                    end
                    M_DOWN: begin
                        tmr = tmr - 1;
                        if (tmr == 0) begin
                            lvl = lvl - 1;
                            if (lvl == 0) mode = M_OFF;
                            else tmr = DELAY;
                        end
                    end
                    default: if (fault_clr && !en) begin
                        mode = M_OFF; flt = 1'b0;
                    end
                endcase
            end
            m_lvl <= lvl; m_mode <= mode; m_tmr <= tmr; m_max <= mx; m_flt <= flt;
        end
    end

    function automatic int model_vec();
        int st;
        case (m_mode)
            M_OFF:   st = 0;
            M_UP:    st = m_lvl;
            M_ON:    st = 5;
            M_DOWN:  st = 6;
            default: st = 7;
        endcase
        return {22'd0, (m_lvl == 0), (m_lvl >= 2), (m_lvl >= 3), (m_lvl >= 4),
                (m_mode == M_ON), (m_mode == M_UP || m_mode == M_DOWN), m_flt, st[2:0]};
    endfunction

    always @(negedge clk) begin
        int  dv;
        logic inv;
        dv = {22'd0, rails_oe_n, rail_lp15v, rail_lp30v, rail_lp60v, ready, busy, fault, state};
        chk("cycle_outputs", dv, model_vec());
        inv = (!(rail_lp15v | rail_lp30v | rail_lp60v) || !rails_oe_n)
              && (!rail_lp30v || rail_lp15v)
              && (!rail_lp60v || rail_lp30v)
              && (!ready || state == 3'd5);
        chk("invariants", int'(inv), 1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_edge(input int n);
        int guard;
        guard = 0;
        while (ec < n && guard < 2000) begin
            step();
            guard++;
        end
        if (ec != n) chk("edge_reach", ec, n);
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; kill = 1'b0; fault_clr = 1'b0;
        step();
        step();
        dchk("rst_oe_n", int'(rails_oe_n), 1);
        dchk("rst_state", int'(state), 0);
        dchk("rst_flags", int'({ready, busy, fault, rail_lp15v, rail_lp30v, rail_lp60v}), 0);
        rst = 1'b0;
    endtask

    initial begin
        // ---- full power-up then power-down, max_rail = 3 ----
        do_reset();
        max_rail = 2'd3;
        at_edge(9);  en = 1'b1;
        at_edge(10); dchk("up_oe_n", int'(rails_oe_n), 0); dchk("up_state", int'(state), 1);
                     dchk("up_busy", int'(busy), 1);
        at_edge(13); dchk("up_lp15_early", int'(rail_lp15v), 0);
        at_edge(14); dchk("up_lp15", int'(rail_lp15v), 1); dchk("up_state15", int'(state), 2);
        at_edge(18); dchk("up_lp30", int'(rail_lp30v), 1);
        at_edge(22); dchk("up_lp60", int'(rail_lp60v), 1); dchk("up_state60", int'(state), 4);
        at_edge(25); dchk("up_ready_early", int'(ready), 0); dchk("up_busy_25", int'(busy), 1);
        at_edge(26); dchk("up_ready", int'(ready), 1); dchk("up_state_on", int'(state), 5);
                     dchk("up_busy_done", int'(busy), 0);
        at_edge(39); en = 1'b0;
        at_edge(40); dchk("dn_lp60", int'(rail_lp60v), 0); dchk("dn_lp30_hold", int'(rail_lp30v), 1);
                     dchk("dn_ready", int'(ready), 0); dchk("dn_state", int'(state), 6);
        at_edge(44); dchk("dn_lp30", int'(rail_lp30v), 0); dchk("dn_lp15_hold", int'(rail_lp15v), 1);
        at_edge(48); dchk("dn_lp15", int'(rail_lp15v), 0); dchk("dn_oe_hold", int'(rails_oe_n), 0);
        at_edge(52); dchk("dn_oe_n", int'(rails_oe_n), 1); dchk("dn_state_off", int'(state), 0);
                     dchk("dn_busy", int'(busy), 0);

        // ---- partial power-up, max_rail = 1 ----
        do_reset();
        max_rail = 2'd1;
        at_edge(9);  en = 1'b1;
        at_edge(14); dchk("pu_lp15", int'(rail_lp15v), 1);
        at_edge(17); dchk("pu_ready_early", int'(ready), 0);
        at_edge(18); dchk("pu_ready", int'(ready), 1); dchk("pu_lp30", int'(rail_lp30v), 0);
        at_edge(20); max_rail = 2'd3;
        at_edge(30); dchk("pu_lp30_late", int'(rail_lp30v), 0); dchk("pu_lp60_late", int'(rail_lp60v), 0);
                     dchk("pu_state", int'(state), 5);

        // ---- abort mid power-up ----
        do_reset();
        max_rail = 2'd3;
        at_edge(9);  en = 1'b1;
        at_edge(15); en = 1'b0;
        at_edge(16); dchk("ab_lp15", int'(rail_lp15v), 0); dchk("ab_state", int'(state), 6);
                     dchk("ab_oe_hold", int'(rails_oe_n), 0);
        at_edge(17); en = 1'b1;
        at_edge(19); dchk("ab_en_ignored", int'(state), 6); dchk("ab_lp30", int'(rail_lp30v), 0);
        at_edge(20); dchk("ab_oe_n", int'(rails_oe_n), 1); dchk("ab_state_off", int'(state), 0);
        at_edge(21); dchk("ab_restart", int'(state), 1); dchk("ab_restart_oe", int'(rails_oe_n), 0);
        en = 1'b0;
        at_edge(22); dchk("ab_oe_only_off", int'(state), 0);

        // ---- kill and fault clear ----
        do_reset();
        max_rail = 2'd3;
        at_edge(9);  en = 1'b1;
        at_edge(19); kill = 1'b1;
        at_edge(20); dchk("kl_oe_n", int'(rails_oe_n), 1); dchk("kl_lp15", int'(rail_lp15v), 0);
                     dchk("kl_fault", int'(fault), 1); dchk("kl_state", int'(state), 7);
                     dchk("kl_ready_busy", int'({ready, busy}), 0);
                     kill = 1'b0; fault_clr = 1'b1;
        at_edge(21); dchk("kl_clr_en_high", int'(state), 7);
                     fault_clr = 1'b0; en = 1'b0;
        at_edge(22); kill = 1'b1; fault_clr = 1'b1;
        at_edge(23); dchk("kl_clr_with_kill", int'(state), 7); dchk("kl_fault_held", int'(fault), 1);
                     kill = 1'b0; fault_clr = 1'b0;
        at_edge(24); fault_clr = 1'b1;
        at_edge(25); dchk("kl_cleared_state", int'(state), 0); dchk("kl_cleared_fault", int'(fault), 0);
                     fault_clr = 1'b0;

        // ---- asynchronous reset in U30 ----
        do_reset();
        max_rail = 2'd3;
        at_edge(9);  en = 1'b1;
        at_edge(19); dchk("ar_in_u30", int'(state), 3);
        #2 rst = 1'b1;
        #1 dchk("ar_oe_n", int'(rails_oe_n), 1);
           dchk("ar_rails", int'({rail_lp15v, rail_lp30v, rail_lp60v}), 0);
           dchk("ar_state", int'(state), 0);
           rst = 1'b0;
        at_edge(1);  dchk("ar_restart", int'(state), 1);
        at_edge(17); dchk("ar_ready", int'(ready), 1); dchk("ar_lp60", int'(rail_lp60v), 1);

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
